// File: rtl/pipelined_reduce_tree.sv
// rtl/pipelined_reduce_tree.sv - pipelined N-input bitwise OR/AND/XOR reduction tree with valid/ready
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_data packs NUM_INPUTS operands of WIDTH bits
//   out_valid/out_ready  output handshake; out_data is the WIDTH-bit reduction result
//
// One register stage per tree level (D = $clog2(NUM_INPUTS) stages). Each stage
// behaves like a one-entry buffer: it loads whenever it is empty or its
// downstream neighbour is draining, so bubbles collapse and a full pipeline
// still streams one result per cycle.

module pipelined_reduce_tree #(
    parameter int WIDTH      = 1,
    parameter int NUM_INPUTS = 4,
    parameter int MODE       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data
);

    localparam int D = $clog2(NUM_INPUTS);

    // Identity element: padding an odd operand with it is a pass-through.
    localparam logic [WIDTH-1:0] IDENT = (MODE == 1) ? '1 : '0;

    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("pipelined_reduce_tree: MODE must be 0 (OR), 1 (AND) or 2 (XOR)");
    end

    // Number of nodes held at tree level k (level 0 = the raw operands).
    function automatic int level_nodes(input int k);
        int n;
        n = NUM_INPUTS;
        for (int i = 0; i < k; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (MODE)
            1:       return a & b;
            2:       return a ^ b;
            default: return a | b;
        endcase
    endfunction

    logic [D:0]   v;      // v[0] is the upstream valid, v[k] the stage-k flag
    logic [D+1:1] rdy;    // rdy[k]: stage k may load this cycle

    assign v[0] = in_valid;

    // Ready ripples backwards: a stage can load if it is empty or will be emptied.
    always_comb begin
        rdy[D+1] = out_ready;
        for (int k = D; k >= 1; k--) begin
            rdy[k] = !v[k] || rdy[k+1];
        end
    end

    for (genvar k = 1; k <= D; k++) begin : g_lvl
        localparam int NP = level_nodes(k - 1);
        localparam int NK = level_nodes(k);

        logic [NP*WIDTH-1:0] prev;
        logic [NK*WIDTH-1:0] nxt;
        logic [NK*WIDTH-1:0] data_q;
        logic                valid_q;

        if (k == 1) begin : g_first
            assign prev = in_data;
        end else begin : g_rest
            assign prev = g_lvl[k-1].data_q;
        end

        for (genvar j = 0; j < NK; j++) begin : g_node
            if (2*j + 1 < NP) begin : g_pair
                assign nxt[j*WIDTH +: WIDTH] = op(prev[2*j*WIDTH +: WIDTH],
                                                  prev[(2*j+1)*WIDTH +: WIDTH]);
            end else begin : g_pad
                assign nxt[j*WIDTH +: WIDTH] = op(prev[2*j*WIDTH +: WIDTH], IDENT);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (rdy[k]) begin
                valid_q <= v[k-1];
                // Data only moves with a valid beat so an idle stage keeps its last value.
                if (v[k-1]) begin
                    data_q <= nxt;
                end
            end
        end

        assign v[k] = valid_q;
    end

    assign in_ready  = rdy[1];
    assign out_valid = v[D];
    assign out_data  = g_lvl[D].data_q;

endmodule
